// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM states, strobe bundle, defaults.
package hazard_ctrl_pkg;

    localparam int unsigned REG_ADDR_W_DEF = 5;

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } state_e;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_stall;
        logic mem_wb_flush;
    } strobe_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: prioritised stall/flush strobes for the 5-stage core,
// perf counters and a sticky data-memory timeout flag.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W      = REG_ADDR_W_DEF,
    parameter int unsigned BR_FLUSH_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT     = 255,
    parameter int unsigned CNT_W           = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic                  id_rs1_used_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_rs2_used_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_mem_read_i,
    input  logic                  ex_branch_taken_i,
    input  logic                  imem_ready_i,
    input  logic                  dmem_req_i,
    input  logic                  dmem_ready_i,
    output logic                  pc_stall_o,
    output logic                  if_id_stall_o,
    output logic                  if_id_flush_o,
    output logic                  id_ex_stall_o,
    output logic                  id_ex_flush_o,
    output logic                  ex_mem_stall_o,
    output logic                  mem_wb_flush_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o,
    output logic                  mem_err_o
);

    localparam int unsigned FC_W = $clog2(BR_FLUSH_CYCLES + 1);
    localparam int unsigned WT_W = $clog2(MEM_TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [FC_W-1:0]   cnt_q, cnt_d;
    logic [WT_W-1:0]   wait_q;
    logic              mem_err_q;
    strobe_t           strb;
    logic              memw;
    logic              lu;
    logic              br_accept;

    assign memw = dmem_req_i & ~dmem_ready_i;
    assign lu   = ex_mem_read_i & (ex_rd_i != '0) &
                  ((id_rs1_used_i & (id_rs1_i == ex_rd_i)) |
                   (id_rs2_used_i & (id_rs2_i == ex_rd_i)));

    // State and flush down-counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Fixed-priority hazard resolution; memory wait freezes everything upstream of WB
    always_comb begin
        strb      = '0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        br_accept = 1'b0;
        if (memw) begin
            strb.pc_stall     = 1'b1;
            strb.if_id_stall  = 1'b1;
            strb.id_ex_stall  = 1'b1;
            strb.ex_mem_stall = 1'b1;
            strb.mem_wb_flush = 1'b1;
        end else if (ex_branch_taken_i) begin
            strb.if_id_flush = 1'b1;
            strb.id_ex_flush = 1'b1;
            br_accept        = 1'b1;
            if (BR_FLUSH_CYCLES > 1) begin
                state_d = S_FLUSH;
                cnt_d   = FC_W'(BR_FLUSH_CYCLES - 1);
            end else begin
                state_d = S_RUN;
            end
        end else if (state_q == S_FLUSH) begin
            strb.if_id_flush = 1'b1;
            strb.id_ex_flush = 1'b1;
            if (cnt_q <= FC_W'(1)) begin
                state_d = S_RUN;
            end else begin
                cnt_d = cnt_q - FC_W'(1);
            end
        end else if (lu) begin
            strb.pc_stall    = 1'b1;
            strb.if_id_stall = 1'b1;
            strb.id_ex_flush = 1'b1;
        end else if (!imem_ready_i) begin
            strb.pc_stall    = 1'b1;
            strb.if_id_flush = 1'b1;
        end
        if (!rst_ni) begin
            strb      = '0;
            br_accept = 1'b0;
        end
    end

    // Consecutive memory-wait cycles; mem_err sticks until reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_q    <= '0;
            mem_err_q <= 1'b0;
        end else if (memw) begin
            if (wait_q != WT_W'(MEM_TIMEOUT)) begin
                wait_q <= wait_q + WT_W'(1);
            end
            if (wait_q >= WT_W'(MEM_TIMEOUT - 1)) begin
                mem_err_q <= 1'b1;
            end
        end else begin
            wait_q <= '0;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (strb.pc_stall),
        .cnt_o  (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (br_accept),
        .cnt_o  (flush_cnt_o)
    );

    assign pc_stall_o     = strb.pc_stall;
    assign if_id_stall_o  = strb.if_id_stall;
    assign if_id_flush_o  = strb.if_id_flush;
    assign id_ex_stall_o  = strb.id_ex_stall;
    assign id_ex_flush_o  = strb.id_ex_flush;
    assign ex_mem_stall_o = strb.ex_mem_stall;
    assign mem_wb_flush_o = strb.mem_wb_flush;
    assign mem_err_o      = mem_err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors queue their expected response,
// a monitor pops and compares on every falling edge.
module tb_hazard_ctrl;

    localparam int unsigned CNT_W = 8;

    // strobe order: pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush
    localparam logic [6:0] S_NONE = 7'b0000000;
    localparam logic [6:0] S_LU   = 7'b1100100;
    localparam logic [6:0] S_IFW  = 7'b1010000;
    localparam logic [6:0] S_BR   = 7'b0010100;
    localparam logic [6:0] S_MEMW = 7'b1101011;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic [4:0]       id_rs1_i, id_rs2_i, ex_rd_i;
    logic             id_rs1_used_i, id_rs2_used_i, ex_mem_read_i, ex_branch_taken_i;
    logic             imem_ready_i, dmem_req_i, dmem_ready_i;
    logic             pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o;
    logic             id_ex_flush_o, ex_mem_stall_o, mem_wb_flush_o, mem_err_o;
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

    typedef struct {
        string      nm;
        logic [6:0] s;
        int         st;
        int         fl;
        logic       er;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .id_rs1_i          (id_rs1_i),
        .id_rs1_used_i     (id_rs1_used_i),
        .id_rs2_i          (id_rs2_i),
        .id_rs2_used_i     (id_rs2_used_i),
        .ex_rd_i           (ex_rd_i),
        .ex_mem_read_i     (ex_mem_read_i),
        .ex_branch_taken_i (ex_branch_taken_i),
        .imem_ready_i      (imem_ready_i),
        .dmem_req_i        (dmem_req_i),
        .dmem_ready_i      (dmem_ready_i),
        .pc_stall_o        (pc_stall_o),
        .if_id_stall_o     (if_id_stall_o),
        .if_id_flush_o     (if_id_flush_o),
        .id_ex_stall_o     (id_ex_stall_o),
        .id_ex_flush_o     (id_ex_flush_o),
        .ex_mem_stall_o    (ex_mem_stall_o),
        .mem_wb_flush_o    (mem_wb_flush_o),
        .stall_cnt_o       (stall_cnt_o),
        .flush_cnt_o       (flush_cnt_o),
        .mem_err_o         (mem_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic idle();
        id_rs1_i = '0; id_rs1_used_i = 1'b0;
        id_rs2_i = '0; id_rs2_used_i = 1'b0;
        ex_rd_i = '0; ex_mem_read_i = 1'b0; ex_branch_taken_i = 1'b0;
        imem_ready_i = 1'b1; dmem_req_i = 1'b0; dmem_ready_i = 1'b1;
    endtask

    task automatic lu_in(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2);
        ex_mem_read_i = 1'b1; ex_rd_i = rd;
        id_rs1_i = rs1; id_rs1_used_i = u1;
        id_rs2_i = rs2; id_rs2_used_i = u2;
    endtask

    task automatic memw_in();
        dmem_req_i = 1'b1; dmem_ready_i = 1'b0;
    endtask

    // queue the response for the inputs currently driven, then advance one cycle
    task automatic cyc(input string nm, input logic [6:0] s, input int st, input int fl, input logic er);
        exp_t e;
        e.nm = nm; e.s = s; e.st = st; e.fl = fl; e.er = er;
        q.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    always @(negedge clk_i) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [6:0] act;
            e   = q.pop_front();
            act = {pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o,
                   id_ex_flush_o, ex_mem_stall_o, mem_wb_flush_o};
            n_vec++;
            if (act !== e.s) begin
                n_miss++;
                $display("FAIL %s strobes: got %b expected %b", e.nm, act, e.s);
            end
            if (int'(stall_cnt_o) != e.st) begin
                n_miss++;
                $display("FAIL %s stall_cnt: got %0d expected %0d", e.nm, stall_cnt_o, e.st);
            end
            if (int'(flush_cnt_o) != e.fl) begin
                n_miss++;
                $display("FAIL %s flush_cnt: got %0d expected %0d", e.nm, flush_cnt_o, e.fl);
            end
            if (mem_err_o !== e.er) begin
                n_miss++;
                $display("FAIL %s mem_err: got %b expected %b", e.nm, mem_err_o, e.er);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni = 1'b0;
        idle();
        memw_in(); ex_branch_taken_i = 1'b1;
        @(posedge clk_i); #1;
        cyc("rst_gate", S_NONE, 0, 0, 1'b0);
        rst_ni = 1'b1; idle();
        cyc("idle", S_NONE, 0, 0, 1'b0);

        // load-use on rs1, rd==0, rs2, unused sources
        lu_in(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);  cyc("lu_rs1", S_LU, 0, 0, 1'b0);
        idle();                               cyc("lu_done", S_NONE, 1, 0, 1'b0);
        lu_in(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);  cyc("lu_rd0", S_NONE, 1, 0, 1'b0);
        lu_in(5'd7, 5'd3, 1'b1, 5'd7, 1'b1);  cyc("lu_rs2", S_LU, 1, 0, 1'b0);
        lu_in(5'd7, 5'd7, 1'b0, 5'd7, 1'b0);  cyc("lu_unused", S_NONE, 2, 0, 1'b0);
        idle(); imem_ready_i = 1'b0;          cyc("if_wait", S_IFW, 2, 0, 1'b0);

        // taken branch: two flush cycles
        idle(); ex_branch_taken_i = 1'b1;     cyc("br0", S_BR, 3, 0, 1'b0);
        idle();                               cyc("br1", S_BR, 3, 1, 1'b0);
        cyc("br_end", S_NONE, 3, 1, 1'b0);

        // load-use ignored in S_FLUSH
        ex_branch_taken_i = 1'b1;             cyc("brlu0", S_BR, 3, 1, 1'b0);
        idle(); lu_in(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        cyc("flush_lu_ign", S_BR, 3, 2, 1'b0);
        idle();                               cyc("brlu_end", S_NONE, 3, 2, 1'b0);

        // second branch inside S_FLUSH reloads the count
        ex_branch_taken_i = 1'b1;             cyc("rel0", S_BR, 3, 2, 1'b0);
        ex_branch_taken_i = 1'b1;             cyc("rel1", S_BR, 3, 3, 1'b0);
        idle();                               cyc("rel2", S_BR, 3, 4, 1'b0);
        cyc("rel_end", S_NONE, 3, 4, 1'b0);

        // three-cycle memory wait
        memw_in();                            cyc("memw0", S_MEMW, 3, 4, 1'b0);
        cyc("memw1", S_MEMW, 4, 4, 1'b0);
        cyc("memw2", S_MEMW, 5, 4, 1'b0);
        dmem_ready_i = 1'b1;                  cyc("memw_done", S_NONE, 6, 4, 1'b0);
        idle();                               cyc("memw_idle", S_NONE, 6, 4, 1'b0);

        // branch held during memory wait is taken when wait clears
        memw_in(); ex_branch_taken_i = 1'b1;  cyc("mwbr0", S_MEMW, 6, 4, 1'b0);
        cyc("mwbr1", S_MEMW, 7, 4, 1'b0);
        dmem_ready_i = 1'b1;                  cyc("mwbr_go", S_BR, 8, 4, 1'b0);
        idle();                               cyc("mwbr_fl", S_BR, 8, 5, 1'b0);
        cyc("mwbr_end", S_NONE, 8, 5, 1'b0);

        // memory wait freezes the flush sequence
        ex_branch_taken_i = 1'b1;             cyc("frz0", S_BR, 8, 5, 1'b0);
        idle(); memw_in();                    cyc("frz_w0", S_MEMW, 8, 6, 1'b0);
        cyc("frz_w1", S_MEMW, 9, 6, 1'b0);
        idle();                               cyc("frz_res", S_BR, 10, 6, 1'b0);
        cyc("frz_end", S_NONE, 10, 6, 1'b0);

        // branch beats load-use; load-use beats fetch wait
        lu_in(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); ex_branch_taken_i = 1'b1;
        cyc("br_over_lu", S_BR, 10, 6, 1'b0);
        idle();                               cyc("bol_fl", S_BR, 10, 7, 1'b0);
        cyc("bol_end", S_NONE, 10, 7, 1'b0);
        lu_in(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); imem_ready_i = 1'b0;
        cyc("lu_over_ifw", S_LU, 10, 7, 1'b0);
        idle();                               cyc("lu_ifw_end", S_NONE, 11, 7, 1'b0);

        // timeout after 255 wait cycles; stall counter saturates at 255
        memw_in();
        for (int k = 0; k < 255; k++) begin
            cyc("timeout_wait", S_MEMW, (11 + k > 255) ? 255 : 11 + k, 7, 1'b0);
        end
        idle();                               cyc("err_set", S_NONE, 255, 7, 1'b1);
        cyc("err_sticky", S_NONE, 255, 7, 1'b1);

        // reset in the middle of S_FLUSH
        ex_branch_taken_i = 1'b1;             cyc("pre_rst_br", S_BR, 255, 7, 1'b1);
        rst_ni = 1'b0;                        cyc("rst_mid", S_NONE, 0, 0, 1'b0);
        rst_ni = 1'b1; idle();                cyc("post_rst", S_NONE, 0, 0, 1'b0);
        lu_in(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);  cyc("post_rst_lu", S_LU, 0, 0, 1'b0);
        idle();                               cyc("post_rst_cnt", S_NONE, 1, 0, 1'b0);

        @(negedge clk_i);
        @(negedge clk_i);
        if (q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
